// File: rtl/fb_ctrl_pkg.sv
// Shared types and constants for the framebuffer page-flip controller.
package fb_ctrl_pkg;

   // Controller sequencing states
   typedef enum logic [2:0] {
      StInitAddr,
      StInitEn,
      StIdle,
      StWrEn,
      StWaitVbl,
      StWrAddr,
      StDone
   } fb_state_e;

   // Scan-out control port register map
   localparam logic CTRL_REG_ADDR   = 1'b0;
   localparam logic CTRL_REG_STATUS = 1'b1;

   // Default frame geometry: one 32-bit word per pixel
   localparam int unsigned FB_WIDTH       = 1024;
   localparam int unsigned FB_HEIGHT      = 768;
   localparam logic [31:0] FB_WORD_STRIDE = 32'(FB_WIDTH * FB_HEIGHT);

   // Word address of buffer idx; wraps mod 2^32
   function automatic logic [31:0] fb_base_of(logic [31:0] base, logic [31:0] stride,
                                              logic [1:0] idx);
      return base + stride * {30'b0, idx};
   endfunction

endpackage

// File: rtl/fb_vbl_timer.sv
// Clearable cycle counter that flags the last cycle of the frame-end wait window.
module fb_vbl_timer #(
   parameter int unsigned VBL_TIMEOUT = 2_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic tc
);

   logic [31:0] count_q;

   assign tc = (count_q == 32'(VBL_TIMEOUT - 1));

   // Count while enabled; hold at terminal count so a stalled wait never wraps
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count_q <= '0;
      end else if (enable && !tc) begin
         count_q <= count_q + 32'd1;
      end
   end

endmodule

// File: rtl/fb_flip_controller.sv
// Page-flip controller: reprograms the scan-out start address only at frame end,
// tracks front/back buffers, gates scan-out enable and counts displayed frames.
module fb_flip_controller
   import fb_ctrl_pkg::*;
#(
   parameter int unsigned NUM_BUFFERS     = 2,
   parameter logic [31:0] FB_BASE         = 32'h1100_0000,
   parameter logic [31:0] FB_STRIDE       = FB_WORD_STRIDE,
   parameter int unsigned VBL_TIMEOUT     = 2_000_000,
   parameter logic        ENABLE_AT_RESET = 1'b0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_flip,
   input  logic        req_enable,
   input  logic        req_disable,
   input  logic        frame_end,
   output logic        ctrl_chep,
   output logic        ctrl_write,
   output logic        ctrl_address,
   output logic [31:0] ctrl_data,
   output logic [1:0]  front_idx,
   output logic [1:0]  back_idx,
   output logic [31:0] back_addr,
   output logic        flip_pending,
   output logic        flip_done,
   output logic        disp_enabled,
   output logic [31:0] frame_cnt
);

   fb_state_e   state_q, state_d;
   logic        pend_en_q, pend_en_d;
   logic        pend_dis_q, pend_dis_d;
   logic        en_val_q, en_val_d;
   logic        accept_flip;
   logic        timer_clear;
   logic        timer_tc;
   logic [1:0]  next_back;

   assign next_back = (back_idx == 2'(NUM_BUFFERS - 1)) ? 2'd0 : back_idx + 2'd1;

   fb_vbl_timer #(
      .VBL_TIMEOUT (VBL_TIMEOUT)
   ) u_vbl_timer (
      .clk    (clk),
      .reset  (reset),
      .clear  (timer_clear),
      .enable (state_q == StWaitVbl),
      .tc     (timer_tc)
   );

   // Next-state, sticky enable/disable requests and flip acceptance
   always_comb begin
      state_d     = state_q;
      pend_en_d   = pend_en_q | req_enable;
      pend_dis_d  = pend_dis_q | req_disable;
      en_val_d    = en_val_q;
      accept_flip = 1'b0;
      timer_clear = 1'b0;
      case (state_q)
         StInitAddr: state_d = StInitEn;
         StInitEn:   state_d = StIdle;
         StIdle: begin
            if (pend_dis_d) begin
               state_d    = StWrEn;
               en_val_d   = 1'b0;
               pend_en_d  = 1'b0;
               pend_dis_d = 1'b0;
            end else if (pend_en_d) begin
               state_d    = StWrEn;
               en_val_d   = 1'b1;
               pend_en_d  = 1'b0;
               pend_dis_d = 1'b0;
            end else if (req_flip && !flip_pending) begin
               state_d     = StWaitVbl;
               accept_flip = 1'b1;
               timer_clear = 1'b1;
            end
         end
         StWrEn: state_d = StIdle;
         StWaitVbl: begin
            // A disabled display has no frame end to wait for
            if (frame_end || timer_tc || !disp_enabled) begin
               state_d = StWrAddr;
            end
         end
         StWrAddr: state_d = StDone;
         StDone:   state_d = StIdle;
         default:  state_d = StInitAddr;
      endcase
   end

   // Registered state, control-port writes, buffer indices and frame counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StInitAddr;
         pend_en_q    <= 1'b0;
         pend_dis_q   <= 1'b0;
         en_val_q     <= 1'b0;
         ctrl_chep    <= 1'b0;
         ctrl_write   <= 1'b0;
         ctrl_address <= 1'b0;
         ctrl_data    <= '0;
         front_idx    <= 2'd0;
         back_idx     <= 2'd1;
         back_addr    <= fb_base_of(FB_BASE, FB_STRIDE, 2'd1);
         flip_pending <= 1'b0;
         flip_done    <= 1'b0;
         disp_enabled <= 1'b0;
         frame_cnt    <= '0;
      end else begin
         state_q    <= state_d;
         pend_en_q  <= pend_en_d;
         pend_dis_q <= pend_dis_d;
         en_val_q   <= en_val_d;
         ctrl_chep  <= 1'b0;
         ctrl_write <= 1'b0;
         flip_done  <= 1'b0;
         back_addr  <= fb_base_of(FB_BASE, FB_STRIDE, back_idx);
         if (frame_end) begin
            frame_cnt <= frame_cnt + 32'd1;
         end
         if (accept_flip) begin
            flip_pending <= 1'b1;
         end
         case (state_q)
            StInitAddr: begin
               ctrl_chep    <= 1'b1;
               ctrl_write   <= 1'b1;
               ctrl_address <= CTRL_REG_ADDR;
               ctrl_data    <= FB_BASE;
            end
            StInitEn: begin
               ctrl_chep    <= 1'b1;
               ctrl_write   <= 1'b1;
               ctrl_address <= CTRL_REG_STATUS;
               ctrl_data    <= {31'b0, ENABLE_AT_RESET};
               disp_enabled <= ENABLE_AT_RESET;
            end
            StWrEn: begin
               ctrl_chep    <= 1'b1;
               ctrl_write   <= 1'b1;
               ctrl_address <= CTRL_REG_STATUS;
               ctrl_data    <= {31'b0, en_val_q};
               disp_enabled <= en_val_q;
            end
            StWrAddr: begin
               ctrl_chep    <= 1'b1;
               ctrl_write   <= 1'b1;
               ctrl_address <= CTRL_REG_ADDR;
               ctrl_data    <= fb_base_of(FB_BASE, FB_STRIDE, back_idx);
            end
            StDone: begin
               front_idx    <= back_idx;
               back_idx     <= next_back;
               flip_pending <= 1'b0;
               flip_done    <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fb_flip_controller.sv
// Self-checking bench for fb_flip_controller: control-port writes are checked
// through a scoreboard queue, timing and indices inline in each scenario task.
module tb_fb_flip_controller;

   localparam int NBUF = 3;
   localparam int VTO  = 40;

   typedef struct packed {
      logic        addr;
      logic [31:0] data;
   } wr_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_flip = 1'b0;
   logic        req_enable = 1'b0;
   logic        req_disable = 1'b0;
   logic        frame_end = 1'b0;
   logic        ctrl_chep;
   logic        ctrl_write;
   logic        ctrl_address;
   logic [31:0] ctrl_data;
   logic [1:0]  front_idx;
   logic [1:0]  back_idx;
   logic [31:0] back_addr;
   logic        flip_pending;
   logic        flip_done;
   logic        disp_enabled;
   logic [31:0] frame_cnt;

   int  errors = 0;
   int  checks = 0;
   wr_t exp_wr[$];
   int  m_front;
   int  m_back;
   int  m_frames;

   always #5 clk = ~clk;

   fb_flip_controller #(
      .NUM_BUFFERS     (NBUF),
      .FB_BASE         (32'h1100_0000),
      .FB_STRIDE       (32'h000C_0000),
      .VBL_TIMEOUT     (VTO),
      .ENABLE_AT_RESET (1'b0)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req_flip     (req_flip),
      .req_enable   (req_enable),
      .req_disable  (req_disable),
      .frame_end    (frame_end),
      .ctrl_chep    (ctrl_chep),
      .ctrl_write   (ctrl_write),
      .ctrl_address (ctrl_address),
      .ctrl_data    (ctrl_data),
      .front_idx    (front_idx),
      .back_idx     (back_idx),
      .back_addr    (back_addr),
      .flip_pending (flip_pending),
      .flip_done    (flip_done),
      .disp_enabled (disp_enabled),
      .frame_cnt    (frame_cnt)
   );

   function automatic logic [31:0] model_base(int i);
      return 32'h1100_0000 + 32'(i) * 32'h000C_0000;
   endfunction

   // Scoreboard: every observed control write must match the oldest expected one
   always @(negedge clk) begin
      wr_t e;
      if (ctrl_write === 1'b1) begin
         checks++;
         if (exp_wr.size() == 0) begin
            errors++;
            $display("FAIL ctrl_wr_unexpected: got addr=%0d data=%h, required no write",
                     ctrl_address, ctrl_data);
         end else begin
            e = exp_wr.pop_front();
            if (ctrl_address !== e.addr || ctrl_data !== e.data || ctrl_chep !== 1'b1) begin
               errors++;
               $display("FAIL ctrl_wr: got addr=%0d data=%h chep=%b, required addr=%0d data=%h chep=1",
                        ctrl_address, ctrl_data, ctrl_chep, e.addr, e.data);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish, required finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic wait_disp(input logic val, input string name);
      int n = 0;
      while (disp_enabled !== val && n < 10) begin
         tick();
         n++;
      end
      checks++;
      if (disp_enabled !== val) begin
         errors++;
         $display("FAIL %s: got disp_enabled=%b, required %b", name, disp_enabled, val);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      frame_end = 1'b1;
      repeat (3) tick();
      frame_end = 1'b0;
      checks++;
      if (ctrl_write !== 1'b0 || ctrl_chep !== 1'b0) begin
         errors++;
         $display("FAIL rst_ctrl: got write=%b chep=%b, required 0 0", ctrl_write, ctrl_chep);
      end
      checks++;
      if (front_idx !== 2'd0 || back_idx !== 2'd1) begin
         errors++;
         $display("FAIL rst_idx: got front=%0d back=%0d, required 0 1", front_idx, back_idx);
      end
      checks++;
      if (back_addr !== 32'h110C_0000) begin
         errors++;
         $display("FAIL rst_back_addr: got %h, required 110c0000", back_addr);
      end
      checks++;
      if (flip_pending !== 1'b0 || flip_done !== 1'b0 || disp_enabled !== 1'b0) begin
         errors++;
         $display("FAIL rst_flags: got pend=%b done=%b en=%b, required 0 0 0",
                  flip_pending, flip_done, disp_enabled);
      end
      checks++;
      if (frame_cnt !== 32'd0) begin
         errors++;
         $display("FAIL rst_frame_cnt: got %0d, required 0", frame_cnt);
      end
      exp_wr.push_back('{addr: 1'b0, data: 32'h1100_0000});
      exp_wr.push_back('{addr: 1'b1, data: 32'h0});
      m_front = 0;
      m_back = 1;
      m_frames = 0;
      reset = 1'b0;
      tick();
      checks++;
      if (ctrl_write !== 1'b1 || ctrl_address !== 1'b0) begin
         errors++;
         $display("FAIL init_wr1: got write=%b addr=%0d, required 1 0", ctrl_write, ctrl_address);
      end
      tick();
      checks++;
      if (ctrl_write !== 1'b1 || ctrl_address !== 1'b1) begin
         errors++;
         $display("FAIL init_wr2: got write=%b addr=%0d, required 1 1", ctrl_write, ctrl_address);
      end
      tick();
      checks++;
      if (ctrl_write !== 1'b0 || disp_enabled !== 1'b0) begin
         errors++;
         $display("FAIL init_end: got write=%b en=%b, required 0 0", ctrl_write, disp_enabled);
      end
   endtask

   // One flip applied by a frame_end arriving `delay` cycles after acceptance
   task automatic do_vbl_flip(input int delay);
      exp_wr.push_back('{addr: 1'b0, data: model_base(m_back)});
      req_flip = 1'b1;
      tick();
      req_flip = 1'b0;
      checks++;
      if (flip_pending !== 1'b1) begin
         errors++;
         $display("FAIL flip_pending_set: got %b, required 1", flip_pending);
      end
      repeat (delay - 1) tick();
      frame_end = 1'b1;
      tick();
      frame_end = 1'b0;
      m_frames++;
      checks++;
      if (ctrl_write !== 1'b0) begin
         errors++;
         $display("FAIL flip_wr_early: got write=%b, required 0", ctrl_write);
      end
      tick();
      checks++;
      if (ctrl_write !== 1'b1) begin
         errors++;
         $display("FAIL flip_wr_latency: got write=%b, required 1", ctrl_write);
      end
      tick();
      checks++;
      if (flip_done !== 1'b1 || front_idx !== 2'(m_back) || back_idx !== 2'((m_back + 1) % NBUF))
      begin
         errors++;
         $display("FAIL flip_done: got done=%b front=%0d back=%0d, required 1 %0d %0d",
                  flip_done, front_idx, back_idx, m_back, (m_back + 1) % NBUF);
      end
      m_front = m_back;
      m_back = (m_back + 1) % NBUF;
      tick();
      checks++;
      if (flip_done !== 1'b0 || flip_pending !== 1'b0 || back_addr !== model_base(m_back)) begin
         errors++;
         $display("FAIL flip_after: got done=%b pend=%b back_addr=%h, required 0 0 %h",
                  flip_done, flip_pending, back_addr, model_base(m_back));
      end
      checks++;
      if (frame_cnt !== 32'(m_frames)) begin
         errors++;
         $display("FAIL frame_cnt: got %0d, required %0d", frame_cnt, m_frames);
      end
   endtask

   task automatic test_enable_flip;
      exp_wr.push_back('{addr: 1'b1, data: 32'h1});
      req_enable = 1'b1;
      tick();
      req_enable = 1'b0;
      wait_disp(1'b1, "enable");
      do_vbl_flip(20);
   endtask

   task automatic test_multi_buffer;
      do_vbl_flip(7);
      checks++;
      if (front_idx !== 2'd2) begin
         errors++;
         $display("FAIL multi_front2: got %0d, required 2", front_idx);
      end
      do_vbl_flip(3);
      checks++;
      if (front_idx !== 2'd0 || back_addr !== 32'h110C_0000) begin
         errors++;
         $display("FAIL multi_wrap: got front=%0d back_addr=%h, required 0 110c0000",
                  front_idx, back_addr);
      end
   endtask

   task automatic test_disabled_flip;
      exp_wr.push_back('{addr: 1'b1, data: 32'h0});
      req_disable = 1'b1;
      tick();
      req_disable = 1'b0;
      wait_disp(1'b0, "disable");
      exp_wr.push_back('{addr: 1'b0, data: model_base(m_back)});
      req_flip = 1'b1;
      tick();
      req_flip = 1'b0;
      tick();
      checks++;
      if (ctrl_write !== 1'b0) begin
         errors++;
         $display("FAIL dis_wr_t1: got write=%b, required 0", ctrl_write);
      end
      tick();
      checks++;
      if (ctrl_write !== 1'b1) begin
         errors++;
         $display("FAIL dis_wr_t2: got write=%b, required 1", ctrl_write);
      end
      tick();
      checks++;
      if (flip_done !== 1'b1 || front_idx !== 2'(m_back)) begin
         errors++;
         $display("FAIL dis_done_t3: got done=%b front=%0d, required 1 %0d",
                  flip_done, front_idx, m_back);
      end
      m_front = m_back;
      m_back = (m_back + 1) % NBUF;
      tick();
   endtask

   task automatic test_timeout;
      int first_wr = -1;
      int n_done = 0;
      exp_wr.push_back('{addr: 1'b1, data: 32'h1});
      req_enable = 1'b1;
      tick();
      req_enable = 1'b0;
      wait_disp(1'b1, "timeout_enable");
      exp_wr.push_back('{addr: 1'b0, data: model_base(m_back)});
      req_flip = 1'b1;
      tick();
      req_flip = 1'b0;
      for (int k = 1; k <= VTO + 20; k++) begin
         if (k == 5) req_flip = 1'b1;
         if (k == 6) req_flip = 1'b0;
         tick();
         if (ctrl_write === 1'b1 && first_wr < 0) first_wr = k;
         if (flip_done === 1'b1) n_done++;
      end
      checks++;
      if (first_wr != VTO + 1) begin
         errors++;
         $display("FAIL timeout_latency: got write at cycle %0d of wait, required %0d",
                  first_wr - 1, VTO);
      end
      checks++;
      if (n_done != 1) begin
         errors++;
         $display("FAIL timeout_single_flip: got %0d flip_done, required 1", n_done);
      end
      m_front = m_back;
      m_back = (m_back + 1) % NBUF;
   endtask

   task automatic test_pend_both;
      int n_done = 0;
      exp_wr.push_back('{addr: 1'b0, data: model_base(m_back)});
      req_flip = 1'b1;
      tick();
      req_flip = 1'b0;
      req_enable = 1'b1;
      req_disable = 1'b1;
      tick();
      req_enable = 1'b0;
      req_disable = 1'b0;
      exp_wr.push_back('{addr: 1'b1, data: 32'h0});
      repeat (3) tick();
      frame_end = 1'b1;
      tick();
      frame_end = 1'b0;
      m_frames++;
      repeat (12) begin
         tick();
         if (flip_done === 1'b1) n_done++;
      end
      checks++;
      if (n_done != 1 || disp_enabled !== 1'b0) begin
         errors++;
         $display("FAIL pend_both: got done=%0d en=%b, required 1 0", n_done, disp_enabled);
      end
      m_front = m_back;
      m_back = (m_back + 1) % NBUF;
      checks++;
      if (front_idx !== 2'(m_front) || frame_cnt !== 32'(m_frames)) begin
         errors++;
         $display("FAIL pend_both_state: got front=%0d frames=%0d, required %0d %0d",
                  front_idx, frame_cnt, m_front, m_frames);
      end
   endtask

   task automatic test_reset_mid;
      exp_wr.push_back('{addr: 1'b1, data: 32'h1});
      req_enable = 1'b1;
      tick();
      req_enable = 1'b0;
      wait_disp(1'b1, "mid_enable");
      req_flip = 1'b1;
      tick();
      req_flip = 1'b0;
      req_disable = 1'b1;
      tick();
      req_disable = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      checks++;
      if (flip_pending !== 1'b0 || front_idx !== 2'd0 || back_idx !== 2'd1) begin
         errors++;
         $display("FAIL mid_rst: got pend=%b front=%0d back=%0d, required 0 0 1",
                  flip_pending, front_idx, back_idx);
      end
      checks++;
      if (frame_cnt !== 32'd0 || disp_enabled !== 1'b0 || back_addr !== 32'h110C_0000) begin
         errors++;
         $display("FAIL mid_rst_regs: got frames=%0d en=%b back_addr=%h, required 0 0 110c0000",
                  frame_cnt, disp_enabled, back_addr);
      end
      exp_wr.push_back('{addr: 1'b0, data: 32'h1100_0000});
      exp_wr.push_back('{addr: 1'b1, data: 32'h0});
      m_front = 0;
      m_back = 1;
      m_frames = 0;
      reset = 1'b0;
      tick();
      checks++;
      if (ctrl_write !== 1'b1 || ctrl_address !== 1'b0) begin
         errors++;
         $display("FAIL mid_init1: got write=%b addr=%0d, required 1 0", ctrl_write, ctrl_address);
      end
      tick();
      checks++;
      if (ctrl_write !== 1'b1 || ctrl_address !== 1'b1) begin
         errors++;
         $display("FAIL mid_init2: got write=%b addr=%0d, required 1 1", ctrl_write, ctrl_address);
      end
      repeat (6) tick();
      checks++;
      if (flip_done !== 1'b0 || flip_pending !== 1'b0 || disp_enabled !== 1'b0) begin
         errors++;
         $display("FAIL mid_settle: got done=%b pend=%b en=%b, required 0 0 0",
                  flip_done, flip_pending, disp_enabled);
      end
   endtask

   initial begin
      test_reset();
      test_enable_flip();
      test_multi_buffer();
      test_disabled_flip();
      test_timeout();
      test_pend_both();
      test_reset_mid();
      repeat (3) tick();
      checks++;
      if (exp_wr.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: got %0d writes outstanding, required 0", exp_wr.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
